// File: rtl/sensor_ts_merge_buffer.sv
// sensor_ts_merge_buffer: NUM_CH timestamped circular FIFOs merged into one
// timestamp-ordered output stream behind a registered valid/ready stage.
// Optional age-based head discard is compiled in with SENSOR_TS_STALE_DROP_EN
// (adds now_ts input and stale_cnt output).

// Per-channel FIFO: storage, pointers, occupancy and sticky overflow flag.
module sensor_ts_ch_fifo #(
  parameter int DATA_WIDTH  = 512,
  parameter int TS_WIDTH    = 64,
  parameter int DEPTH       = 16,
  parameter int DROP_OLDEST = 0,
  parameter int CW          = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [TS_WIDTH-1:0]   wr_ts,
  input  logic                  pop,
  input  logic                  ovf_clr,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [TS_WIDTH-1:0]   head_ts,
  output logic [CW-1:0]         count,
  output logic                  empty,
  output logic                  ovf_flag
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [TS_WIDTH-1:0]   mem_ts   [DEPTH];
  logic [AW-1:0]         wptr, rptr;
  logic [CW-1:0]         cnt;
  logic                  ovf_q;
  logic                  full, push, overwrite, ovf_set;

  // Write policy: reject-when-full, or overwrite the oldest entry when full.
  // A same-cycle pop frees a slot, so overwrite only happens without a pop.
  always_comb begin
    full      = (cnt == FULL_CNT);
    push      = 1'b0;
    overwrite = 1'b0;
    ovf_set   = 1'b0;
    if (DROP_OLDEST != 0) begin
      push      = wr_valid;
      overwrite = wr_valid && full && !pop;
      ovf_set   = overwrite;
    end else begin
      push      = wr_valid && !full;
      ovf_set   = wr_valid && full;
    end
  end

  assign wr_ready  = (DROP_OLDEST != 0) ? 1'b1 : !full;
  assign head_data = mem_data[rptr];
  assign head_ts   = mem_ts[rptr];
  assign count     = cnt;
  assign empty     = (cnt == '0);
  assign ovf_flag  = ovf_q;

  // Pointers wrap naturally (DEPTH is a power of two); overwrite advances head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push)
        wptr <= wptr + 1'b1;
      if (pop || overwrite)
        rptr <= rptr + 1'b1;
      if (push && !pop && !overwrite)
        cnt <= cnt + 1'b1;
      else if (pop && !push)
        cnt <= cnt - 1'b1;
      // a set event in the same cycle wins over the clear
      if (ovf_set)
        ovf_q <= 1'b1;
      else if (ovf_clr)
        ovf_q <= 1'b0;
    end
  end

  // Entry storage, intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wptr] <= wr_data;
      mem_ts[wptr]   <= wr_ts;
    end
  end
endmodule

// Top: channel array, oldest-head selection and the output register.
module sensor_ts_merge_buffer #(
  parameter int NUM_CH      = 4,
  parameter int DATA_WIDTH  = 512,
  parameter int TS_WIDTH    = 64,
  parameter int DEPTH       = 16,
  parameter int DROP_OLDEST = 0,
  parameter int MAX_AGE     = 1000
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_CH-1:0]                    wr_valid,
  output logic [NUM_CH-1:0]                    wr_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0]         wr_data,
  input  logic [NUM_CH*TS_WIDTH-1:0]           wr_ts,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DATA_WIDTH-1:0]                out_data,
  output logic [TS_WIDTH-1:0]                  out_ts,
  output logic [((NUM_CH>1)?$clog2(NUM_CH):1)-1:0] out_ch,
  output logic [NUM_CH*($clog2(DEPTH)+1)-1:0]  count,
  output logic [NUM_CH-1:0]                    ovf_flag,
`ifdef SENSOR_TS_STALE_DROP_EN
  input  logic [TS_WIDTH-1:0]                  now_ts,
  output logic [15:0]                          stale_cnt,
`endif
  input  logic [NUM_CH-1:0]                    ovf_clr
);
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0][DATA_WIDTH-1:0] head_data;
  logic [NUM_CH-1:0][TS_WIDTH-1:0]   head_ts;
  logic [NUM_CH-1:0]                 empty, pop, sel_pop, stale;
  logic                              any_elig, load_en;
  logic [CHW-1:0]                    sel_idx;
  logic [TS_WIDTH-1:0]               best_ts;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    sensor_ts_ch_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .TS_WIDTH   (TS_WIDTH),
      .DEPTH      (DEPTH),
      .DROP_OLDEST(DROP_OLDEST),
      .CW         (CW)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_valid (wr_valid[c]),
      .wr_ready (wr_ready[c]),
      .wr_data  (wr_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .wr_ts    (wr_ts[c*TS_WIDTH +: TS_WIDTH]),
      .pop      (pop[c]),
      .ovf_clr  (ovf_clr[c]),
      .head_data(head_data[c]),
      .head_ts  (head_ts[c]),
      .count    (count[c*CW +: CW]),
      .empty    (empty[c]),
      .ovf_flag (ovf_flag[c])
    );
  end

`ifdef SENSOR_TS_STALE_DROP_EN
  localparam int NSW = $clog2(NUM_CH + 1);
  logic [NSW-1:0] n_stale;
  logic [16:0]    stale_sum;

  // Heads older than MAX_AGE are discarded; a head "from the future" never is.
  always_comb begin
    stale   = '0;
    n_stale = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      stale[c] = !empty[c] && (now_ts >= head_ts[c]) &&
                 ((now_ts - head_ts[c]) > TS_WIDTH'(MAX_AGE));
      n_stale  = n_stale + NSW'(stale[c]);
    end
  end

  assign stale_sum = {1'b0, stale_cnt} + 17'(n_stale);

  // Saturating count of age discards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stale_cnt <= '0;
    else
      stale_cnt <= stale_sum[16] ? 16'hFFFF : stale_sum[15:0];
  end
`else
  assign stale = '0;
`endif

  // Oldest head wins; strict less-than keeps ties on the lowest channel.
  always_comb begin
    any_elig = 1'b0;
    sel_idx  = '0;
    best_ts  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!empty[c] && !stale[c] && (!any_elig || head_ts[c] < best_ts)) begin
        any_elig = 1'b1;
        sel_idx  = CHW'(c);
        best_ts  = head_ts[c];
      end
    end
  end

  assign load_en = !out_valid || out_ready;

  // Pop the selected head only when the output register takes it.
  always_comb begin
    sel_pop = '0;
    if (load_en && any_elig)
      sel_pop[sel_idx] = 1'b1;
  end

  assign pop = sel_pop | stale;

  // Output register: refills whenever empty or being accepted downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ts    <= '0;
      out_ch    <= '0;
    end else if (load_en) begin
      out_valid <= any_elig;
      if (any_elig) begin
        out_data <= head_data[sel_idx];
        out_ts   <= best_ts;
        out_ch   <= sel_idx;
      end
    end
  end
endmodule

// File: tb/tb_sensor_ts_merge_buffer.sv
// Directed bench for sensor_ts_merge_buffer: stimulus pushes expected entries
// into per-DUT queues, negedge monitors pop and compare on each transfer.
// dut0 rejects when full, dut1 overwrites the oldest entry.
module tb_sensor_ts_merge_buffer;
  localparam int NC = 4, DW = 32, TW = 64, DP = 16, CW = 5, CHW = 2;

  typedef struct packed {
    logic [DW-1:0]  d;
    logic [TW-1:0]  t;
    logic [CHW-1:0] c;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NC-1:0]    wv0, wr0, ovf0, clr0, wv1, wr1, ovf1, clr1;
  logic [NC*DW-1:0] wd0, wd1;
  logic [NC*TW-1:0] wt0, wt1;
  logic             ov0, or0, ov1, or1;
  logic [DW-1:0]    od0, od1;
  logic [TW-1:0]    ot0, ot1;
  logic [CHW-1:0]   oc0, oc1;
  logic [NC*CW-1:0] cnt0, cnt1;
`ifdef SENSOR_TS_STALE_DROP_EN
  logic [TW-1:0]    now0, now1;
  logic [15:0]      sc0, sc1;
`endif

  exp_t q0[$], q1[$];
  int checks = 0, errors = 0;

  sensor_ts_merge_buffer #(.NUM_CH(NC), .DATA_WIDTH(DW), .TS_WIDTH(TW), .DEPTH(DP),
                           .DROP_OLDEST(0), .MAX_AGE(1000)) dut0 (
    .clk(clk), .rst_n(rst_n), .wr_valid(wv0), .wr_ready(wr0), .wr_data(wd0), .wr_ts(wt0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0), .out_ts(ot0), .out_ch(oc0),
    .count(cnt0), .ovf_flag(ovf0),
`ifdef SENSOR_TS_STALE_DROP_EN
    .now_ts(now0), .stale_cnt(sc0),
`endif
    .ovf_clr(clr0));

  sensor_ts_merge_buffer #(.NUM_CH(NC), .DATA_WIDTH(DW), .TS_WIDTH(TW), .DEPTH(DP),
                           .DROP_OLDEST(1), .MAX_AGE(1000)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_valid(wv1), .wr_ready(wr1), .wr_data(wd1), .wr_ts(wt1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_ts(ot1), .out_ch(oc1),
    .count(cnt1), .ovf_flag(ovf1),
`ifdef SENSOR_TS_STALE_DROP_EN
    .now_ts(now1), .stale_cnt(sc1),
`endif
    .ovf_clr(clr1));

  function automatic exp_t mk(input int c, input logic [63:0] t);
    exp_t e;
    e.c = CHW'(c);
    e.t = t;
    e.d = {8'(8'hA0 + c), t[23:0]};
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Scoreboard monitors: a transfer is out_valid && out_ready at the next edge.
  always @(negedge clk) begin
    if (rst_n && ov0 && or0) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL out0_unexpected got_ts=%0d got_ch=%0d expected=none", ot0, oc0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        chk("out0_ts", ot0, e.t);
        chk("out0_ch", 64'(oc0), 64'(e.c));
        chk("out0_data", 64'(od0), 64'(e.d));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov1 && or1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL out1_unexpected got_ts=%0d got_ch=%0d expected=none", ot1, oc1);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("out1_ts", ot1, e.t);
        chk("out1_ch", 64'(oc1), 64'(e.c));
        chk("out1_data", 64'(od1), 64'(e.d));
      end
    end
  end

  task automatic put0(input int c, input logic [63:0] t);
    exp_t e;
    e = mk(c, t);
    wv0[c] = 1'b1; wd0[c*DW +: DW] = e.d; wt0[c*TW +: TW] = t;
  endtask

  task automatic put1(input int c, input logic [63:0] t);
    exp_t e;
    e = mk(c, t);
    wv1[c] = 1'b1; wd1[c*DW +: DW] = e.d; wt1[c*TW +: TW] = t;
  endtask

  // One clock; one-shot controls drop afterwards.
  task automatic tick();
    @(posedge clk); #1;
    wv0 = '0; clr0 = '0; wv1 = '0; clr1 = '0;
  endtask

  task automatic drain(input int which);
    int n = 0;
    while (((which == 0) ? q0.size() : q1.size()) != 0 && n < 100) begin
      @(posedge clk); n++;
    end
    #1;
    chk((which == 0) ? "drain0_left" : "drain1_left",
        64'((which == 0) ? q0.size() : q1.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    wv0 = '0; clr0 = '0; wd0 = '0; wt0 = '0; or0 = 1'b1;
    wv1 = '0; clr1 = '0; wd1 = '0; wt1 = '0; or1 = 1'b1;
`ifdef SENSOR_TS_STALE_DROP_EN
    now0 = '0; now1 = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(ov0), 64'd0);
    chk("rst_count", 64'(cnt0), 64'd0);
    chk("rst_ovf", 64'(ovf0), 64'd0);
    chk("rst_out_ts", ot0, 64'd0);
    chk("rst_wr_ready", 64'(wr0), 64'hF);
    chk("rst_wr_ready_drop", 64'(wr1), 64'hF);
    rst_n = 1'b1;
    tick();

    // Smaller ts wins regardless of channel; first output after one more edge.
    put0(0, 30); put0(1, 10);
    q0.push_back(mk(1, 10)); q0.push_back(mk(0, 30));
    tick();
    chk("latency_edge_n", 64'(ov0), 64'd0);
    tick();
    chk("latency_edge_n1", 64'(ov0), 64'd1);
    drain(0);

    // Tie on ts goes to the lower channel.
    put0(2, 5); put0(3, 5);
    q0.push_back(mk(2, 5)); q0.push_back(mk(3, 5));
    tick();
    drain(0);

    // Three-way ordering.
    put0(0, 7); put0(1, 3); put0(3, 9);
    q0.push_back(mk(1, 3)); q0.push_back(mk(0, 7)); q0.push_back(mk(3, 9));
    tick();
    drain(0);

    // Reject-when-full: the output register takes entry 1, so 17 writes fit
    // (16 in the FIFO) and the 18th is refused and flagged.
    or0 = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      put0(0, 64'(k));
      if (k <= 17) q0.push_back(mk(0, 64'(k)));
      tick();
      if (k == 17) begin
        chk("full_count", 64'(cnt0[0 +: CW]), 64'd16);
        chk("full_wr_ready", 64'(wr0[0]), 64'd0);
        chk("full_no_ovf_yet", 64'(ovf0[0]), 64'd0);
      end
    end
    chk("ovf_set", 64'(ovf0[0]), 64'd1);
    chk("ovf_count_held", 64'(cnt0[0 +: CW]), 64'd16);
    // set and clear together: flag stays set
    put0(0, 99); clr0[0] = 1'b1;
    tick();
    chk("ovf_set_beats_clr", 64'(ovf0[0]), 64'd1);
    clr0[0] = 1'b1;
    tick();
    chk("ovf_cleared", 64'(ovf0[0]), 64'd0);
    // stalled output must hold
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("hold_valid", 64'(ov0), 64'd1);
      chk("hold_ts", ot0, 64'd1);
      chk("hold_data", 64'(od0), 64'(mk(0, 1).d));
    end
    or0 = 1'b1;
    drain(0);

    // Overwrite-oldest: entry 1 sits in the output register, entry 2 is
    // overwritten by the 18th write.
    or1 = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      put1(1, 64'(k));
      if (k != 2) q1.push_back(mk(1, 64'(k)));
      tick();
    end
    chk("drop_count", 64'(cnt1[1*CW +: CW]), 64'd16);
    chk("drop_ovf", 64'(ovf1[1]), 64'd1);
    chk("drop_wr_ready", 64'(wr1[1]), 64'd1);
    or1 = 1'b1;
    drain(1);

    // Async reset mid-stream.
    or0 = 1'b0;
    put0(1, 50); put0(2, 60);
    tick();
    tick();
    chk("pre_rst_valid", 64'(ov0), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(ov0), 64'd0);
    chk("async_rst_count", 64'(cnt0), 64'd0);
    chk("async_rst_ovf1", 64'(ovf1), 64'd0);
    q0.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    or0 = 1'b1;
    tick();
    chk("post_rst_valid", 64'(ov0), 64'd0);

`ifdef SENSOR_TS_STALE_DROP_EN
    // ch0 head is 1100 old (stale), ch1 head is 700 old (kept).
    now0 = 64'd1200;
    put0(0, 100); put0(1, 500);
    q0.push_back(mk(1, 500));
    tick();
    tick();
    chk("stale_cnt", 64'(sc0), 64'd1);
    chk("stale_count_ch0", 64'(cnt0[0 +: CW]), 64'd0);
    drain(0);
    now0 = '0;
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
